rs_decode_arbiter: RTL and testbench
====================================

# rs_decode_arbiter

Shares the single RS(15,9) GF(16) decoder core between two received-word sources. The block arbitrates round-robin between the two sources, launches the decoder with a one-cycle start pulse, and waits for completion under a watchdog. It then returns the 36-bit message, tagged with its channel, on one valid/ready response port. It sits between the two demodulator front-ends and the decoder, and counts uncorrectable and timed-out words.

## Interface
Parameters:
- DEC_TIMEOUT, 64: number of WAIT cycles without decDone before the word is abandoned (legal range 2..255).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ch0ReqValid / ch1ReqValid  in  1  source N holds a received word.
- ch0Word / ch1Word  in  60  received word, symbol i at bits [4i+3:4i].
- ch0ReqReady / ch1ReqReady  out  1  accept strobe for source N.
- decStart  out  1  one-cycle launch pulse to the decoder.
- decWord  out  60  word under decode; held stable from LAUNCH to the end of RESP.
- decDone  in  1  decoder result valid (single-cycle pulse).
- decMessage  in  36  decoded message symbols 6..14.
- decFail  in  1  decoder found more than 3 symbol errors.
- respValid  out  1  response available.
- respReady  in  1  consumer accepts the response.
- respChan  out  1  source index of the response.
- respMessage  out  36  decoded message; 0 on timeout.
- respFail  out  1  copy of decFail.
- respTimeout  out  1  watchdog expired.
- failCount  out  16  saturating count of responses with respFail or respTimeout set.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any chNReqValid is high, grant one source. chNReqReady is combinationally high for the granted source only, in this cycle.
  - Latch the granted word into decWord and the source index into respChan. Go to LAUNCH.
  - Ready outputs are 0 in every other state.
- Arbitration: round-robin. With both sources valid, the source not granted last wins. After reset the pointer favours ch0. The pointer updates only on a grant.
- LAUNCH: decStart=1 for exactly this cycle. Clear the timer. Go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - On decDone: load respMessage←decMessage, respFail←decFail, respTimeout←0; go to RESP.
  - Otherwise, when the timer reaches DEC_TIMEOUT-1: load respMessage←0, respFail←0, respTimeout←1; go to RESP.
  - If decDone and expiry occur in the same cycle, decDone wins.
- RESP:
  - respValid=1. All resp* outputs stay stable until respReady.
  - On respValid&respReady, go to IDLE.
  - failCount increments, saturating at 16'hFFFF, on the accept of any response with respFail|respTimeout.
- decDone outside WAIT is ignored (a late pulse from an abandoned word is not forwarded). decBusy is not used.
- Reset mid-operation: all state is discarded immediately and no response is produced for the in-flight word.

## Timing
- Reset values:
  - State = IDLE, arbitration pointer = ch0, timer = 0.
  - decStart=0, decWord=0.
  - respValid=0, respChan=0, respMessage=0, respFail=0, respTimeout=0.
  - failCount=0, ch0ReqReady=0, ch1ReqReady=0.
- Accept in cycle N, then decStart in cycle N+1.
- decDone sampled in cycle M, then respValid high from cycle M+1.
- Timeout: respValid rises DEC_TIMEOUT+1 cycles after the decStart cycle.
- Response accepted in cycle R, then the next grant is possible in cycle R+1. Minimum request-to-request spacing is 4 cycles plus decoder latency.
- All outputs are registered except chNReqReady.

## Structure
- Package rs_pkg holds:
  - RS_N=15, RS_K=9, SYM_W=4, WORD_W=60, MSG_W=36.
  - The FSM state enum.
  - The failCount width (16).
- The decoder core and any GF arithmetic do not live here.
- Sub-module rr_arbiter2: a two-way round-robin grant with a last-grant pointer register and an advance-on-grant input. Everything else stays in rs_decode_arbiter.

## Test plan
- ch0 word 60'h0 valid, decoder model answers after 5 cycles with decMessage=36'h123456789 → decStart one cycle after accept; respValid 6 cycles after decStart with respChan=0, respMessage=36'h123456789, respFail=0, respTimeout=0.
- After reset, both sources valid continuously with respReady=1 → grants ch0, ch1, ch0, ch1; the ready outputs are never high together.
- Decoder returns decFail=1 → respFail=1, and failCount goes 0→1 on accept; a following clean word leaves it at 1.
- DEC_TIMEOUT=8, decoder silent → respTimeout=1 and respMessage=0 with respValid 9 cycles after decStart. A decDone injected 3 cycles later, during IDLE, produces no response.
- respReady held low 10 cycles in RESP with ch1 valid → resp* and decWord stable, ch1ReqReady=0, no decStart; ch1 is granted the cycle after the accept.
- rst_n pulled low during WAIT → all outputs go to their reset values asynchronously, no response appears after release, and a decDone following release is ignored.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants and FSM state type for the RS(15,9) decoder front-end arbiter.
package rs_pkg;
    localparam int unsigned RS_N       = 15;
    localparam int unsigned RS_K       = 9;
    localparam int unsigned SYM_W      = 4;
    localparam int unsigned WORD_W     = RS_N * SYM_W;
    localparam int unsigned MSG_W      = RS_K * SYM_W;
    localparam int unsigned FAIL_CNT_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp
    } state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves to the other source after each grant.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);
    // 1 means ch1 is favoured on the next contested grant
    logic prio_q, prio_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
endmodule

// File: rtl/rs_decode_arbiter.sv
// Shares one RS(15,9) decoder between two sources: round-robin grant, launch,
// watchdog-bounded wait and a tagged valid/ready response with a failure counter.
module rs_decode_arbiter
    import rs_pkg::*;
#(
    parameter int unsigned DEC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ch0ReqValid,
    input  logic                  ch1ReqValid,
    input  logic [WORD_W-1:0]     ch0Word,
    input  logic [WORD_W-1:0]     ch1Word,
    output logic                  ch0ReqReady,
    output logic                  ch1ReqReady,
    output logic                  decStart,
    output logic [WORD_W-1:0]     decWord,
    input  logic                  decDone,
    input  logic [MSG_W-1:0]      decMessage,
    input  logic                  decFail,
    output logic                  respValid,
    input  logic                  respReady,
    output logic                  respChan,
    output logic [MSG_W-1:0]      respMessage,
    output logic                  respFail,
    output logic                  respTimeout,
    output logic [FAIL_CNT_W-1:0] failCount
);
    localparam logic [7:0] TimerLast = 8'(DEC_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [7:0]            timer_q, timer_d;
    logic                  dec_start_q, dec_start_d;
    logic [WORD_W-1:0]     dec_word_q, dec_word_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_chan_q, resp_chan_d;
    logic [MSG_W-1:0]      resp_msg_q, resp_msg_d;
    logic                  resp_fail_q, resp_fail_d;
    logic                  resp_tmo_q, resp_tmo_d;
    logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [1:0]            gnt;
    logic                  in_idle;

    assign in_idle = (state_q == StIdle);

    rr_arbiter2 u_arb (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     ({ch1ReqValid, ch0ReqValid}),
        .advance_i (in_idle),
        .gnt_o     (gnt)
    );

    assign ch0ReqReady = in_idle & gnt[0];
    assign ch1ReqReady = in_idle & gnt[1];
    assign decStart    = dec_start_q;
    assign decWord     = dec_word_q;
    assign respValid   = resp_valid_q;
    assign respChan    = resp_chan_q;
    assign respMessage = resp_msg_q;
    assign respFail    = resp_fail_q;
    assign respTimeout = resp_tmo_q;
    assign failCount   = fail_cnt_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        dec_start_d  = 1'b0;
        dec_word_d   = dec_word_q;
        resp_valid_d = resp_valid_q;
        resp_chan_d  = resp_chan_q;
        resp_msg_d   = resp_msg_q;
        resp_fail_d  = resp_fail_q;
        resp_tmo_d   = resp_tmo_q;
        fail_cnt_d   = fail_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    dec_word_d  = gnt[1] ? ch1Word : ch0Word;
                    resp_chan_d = gnt[1];
                    dec_start_d = 1'b1;
                    state_d     = StLaunch;
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // A completion in the expiry cycle still wins over the watchdog
                if (decDone) begin
                    resp_msg_d   = decMessage;
                    resp_fail_d  = decFail;
                    resp_tmo_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else if (timer_q == TimerLast) begin
                    resp_msg_d   = '0;
                    resp_fail_d  = 1'b0;
                    resp_tmo_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StResp: begin
                if (respReady) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                    if ((resp_fail_q || resp_tmo_q) && (fail_cnt_q != {FAIL_CNT_W{1'b1}})) begin
                        fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            dec_start_q  <= 1'b0;
            dec_word_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_chan_q  <= 1'b0;
            resp_msg_q   <= '0;
            resp_fail_q  <= 1'b0;
            resp_tmo_q   <= 1'b0;
            fail_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            dec_start_q  <= dec_start_d;
            dec_word_q   <= dec_word_d;
            resp_valid_q <= resp_valid_d;
            resp_chan_q  <= resp_chan_d;
            resp_msg_q   <= resp_msg_d;
            resp_fail_q  <= resp_fail_d;
            resp_tmo_q   <= resp_tmo_d;
            fail_cnt_q   <= fail_cnt_d;
        end
    end
endmodule

// File: tb/tb_rs_decode_arbiter.sv
// Self-checking bench for rs_decode_arbiter with a behavioural decoder and arbitration model.
module tb_rs_decode_arbiter;
    localparam int unsigned TO = 8;

    logic        clk, rst_n;
    logic        ch0ReqValid, ch1ReqValid, ch0ReqReady, ch1ReqReady;
    logic [59:0] ch0Word, ch1Word, decWord;
    logic        decStart, decDone, decFail;
    logic [35:0] decMessage, respMessage;
    logic        respValid, respReady, respChan, respFail, respTimeout;
    logic [15:0] failCount;

    int checks = 0;
    int failures = 0;
    int last_gnt;    // source granted most recently (1 after reset so ch0 wins first)
    int fail_model;

    typedef struct {
        logic        rdy0, rdy1, both_rdy, chan, f, t, stable, leak, rv_after;
        int          st, rl;
        logic [59:0] dword;
        logic [35:0] msg;
        logic [15:0] fc;
    } obs_t;

    rs_decode_arbiter #(.DEC_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch0ReqValid (ch0ReqValid),
        .ch1ReqValid (ch1ReqValid),
        .ch0Word     (ch0Word),
        .ch1Word     (ch1Word),
        .ch0ReqReady (ch0ReqReady),
        .ch1ReqReady (ch1ReqReady),
        .decStart    (decStart),
        .decWord     (decWord),
        .decDone     (decDone),
        .decMessage  (decMessage),
        .decFail     (decFail),
        .respValid   (respValid),
        .respReady   (respReady),
        .respChan    (respChan),
        .respMessage (respMessage),
        .respFail    (respFail),
        .respTimeout (respTimeout),
        .failCount   (failCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    function automatic logic [59:0] rnd60();
        return 60'({$urandom(), $urandom()});
    endfunction

    // Source the model expects to win, given which sources are requesting
    function automatic int exp_chan(input logic v0, input logic v1);
        if (v0 && v1) return (last_gnt == 0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ch0ReqValid = 0; ch1ReqValid = 0; ch0Word = '0; ch1Word = '0;
        decDone = 0; decFail = 0; decMessage = '0; respReady = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        last_gnt = 1;
        fail_model = 0;
    endtask

    // One full transaction: request, launch, decoder answer after lat cycles (<=0: silent),
    // optional RESP back-pressure for hold cycles, then accept. Only observes, never judges.
    task automatic xact(input logic v0, input logic v1, input logic [59:0] w0,
                        input logic [59:0] w1, input int lat, input logic [35:0] msg,
                        input logic f, input int hold, input logic keep, input logic late1,
                        output obs_t o);
        ch0ReqValid = v0; ch1ReqValid = v1; ch0Word = w0; ch1Word = w1;
        #1;
        o.rdy0 = ch0ReqReady; o.rdy1 = ch1ReqReady; o.both_rdy = ch0ReqReady & ch1ReqReady;
        o.stable = 1; o.leak = 0;
        cyc();
        if (!keep) begin ch0ReqValid = 0; ch1ReqValid = 0; end
        o.st = 0;
        while (!decStart && o.st < 20) begin cyc(); o.st++; end
        o.dword = decWord;
        o.rl = 0;
        while (!respValid && o.rl < 300) begin
            if (ch0ReqReady || ch1ReqReady) o.leak = 1;
            if (lat > 0 && o.rl == lat) begin decDone = 1; decMessage = msg; decFail = f; end
            cyc();
            decDone = 0; decFail = 0; decMessage = rnd36();
            o.rl++;
            if (decWord !== o.dword) o.stable = 0;
        end
        o.chan = respChan; o.msg = respMessage; o.f = respFail; o.t = respTimeout;
        if (late1) begin ch1ReqValid = 1; ch1Word = w1; end
        for (int i = 0; i < hold; i++) begin
            #1;
            if (ch0ReqReady || ch1ReqReady || decStart) o.leak = 1;
            if (i == 2) begin decDone = 1; decMessage = rnd36(); decFail = 1; end
            cyc();
            decDone = 0; decFail = 0;
            if (respValid !== 1'b1 || respChan !== o.chan || respMessage !== o.msg ||
                respFail !== o.f || respTimeout !== o.t || decWord !== o.dword) o.stable = 0;
        end
        respReady = 1;
        cyc();
        respReady = 0;
        o.fc = failCount;
        o.rv_after = respValid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch0ReqValid = 0; ch1ReqValid = 0; decDone = 0; respReady = 0;
        #3;
        checks++;
        if ({decStart, decWord, respValid, respChan, respMessage, respFail, respTimeout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {decStart, decWord, respValid, respChan, respMessage, respFail, respTimeout});
        end
        checks++;
        if ({failCount, ch0ReqReady, ch1ReqReady} !== 18'd0) begin
            failures++;
            $display("FAIL reset_count_ready got=%h want=0", {failCount, ch0ReqReady, ch1ReqReady});
        end
        do_reset();
    endtask

    task automatic test_basic();
        obs_t o;
        int ec, lat, erl;
        logic [59:0] w;
        logic [35:0] m;
        xact(1, 0, 60'h0, 60'h0, 5, 36'h123456789, 0, 0, 0, 0, o);
        last_gnt = 0;
        checks++;
        if ({o.rdy0, o.rdy1} !== 2'b10) begin
            failures++; $display("FAIL basic_ready got=%b want=10", {o.rdy0, o.rdy1});
        end
        checks++;
        if (o.st != 0) begin failures++; $display("FAIL basic_start_lat got=%0d want=0", o.st); end
        checks++;
        if (o.rl != 6) begin failures++; $display("FAIL basic_resp_lat got=%0d want=6", o.rl); end
        checks++;
        if ({o.chan, o.msg, o.f, o.t} !== {1'b0, 36'h123456789, 2'b00}) begin
            failures++;
            $display("FAIL basic_resp got=%h want=%h", {o.chan, o.msg, o.f, o.t},
                     {1'b0, 36'h123456789, 2'b00});
        end
        checks++;
        if (o.rv_after !== 1'b0 || o.fc !== 16'd0) begin
            failures++; $display("FAIL basic_accept got rv=%b fc=%0d want rv=0 fc=0", o.rv_after, o.fc);
        end
        for (int k = 0; k < 4; k++) begin
            ec = $urandom_range(1, 0);
            lat = $urandom_range(TO, 1);
            erl = lat + 1;
            w = rnd60(); m = rnd36();
            xact(ec == 0, ec == 1, w, ~w, lat, m, 0, 0, 0, 0, o);
            last_gnt = ec;
            checks++;
            if (o.chan !== 1'(ec) || o.msg !== m || o.rl != erl || o.dword !== (ec ? ~w : w)) begin
                failures++;
                $display("FAIL basic_rand chan=%0d msg=%h rl=%0d word=%h want chan=%0d msg=%h rl=%0d word=%h",
                         o.chan, o.msg, o.rl, o.dword, ec, m, erl, ec ? ~w : w);
            end
        end
    endtask

    task automatic test_round_robin();
        obs_t o;
        int ec;
        logic [59:0] w0, w1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            w0 = rnd60(); w1 = rnd60();
            ec = exp_chan(1, 1);
            xact(1, 1, w0, w1, 3, rnd36(), 0, 0, 1, 0, o);
            last_gnt = ec;
            checks++;
            if (o.chan !== 1'(ec) || {o.rdy1, o.rdy0} !== (ec ? 2'b10 : 2'b01) ||
                o.dword !== (ec ? w1 : w0)) begin
                failures++;
                $display("FAIL rr_grant%0d chan=%0d rdy=%b%b want chan=%0d", k, o.chan, o.rdy1, o.rdy0, ec);
            end
            checks++;
            if (o.both_rdy !== 1'b0 || o.leak !== 1'b0) begin
                failures++; $display("FAIL rr_ready_excl%0d both=%b leak=%b want 0", k, o.both_rdy, o.leak);
            end
        end
        ch0ReqValid = 0; ch1ReqValid = 0;
    endtask

    task automatic test_fail_count();
        obs_t o;
        do_reset();
        xact(1, 0, rnd60(), '0, 4, 36'hABCDE0123, 1, 0, 0, 0, o);
        last_gnt = 0; fail_model++;
        checks++;
        if (o.f !== 1'b1 || o.t !== 1'b0 || o.msg !== 36'hABCDE0123) begin
            failures++; $display("FAIL fail_flag f=%b t=%b msg=%h want f=1 t=0 msg=abcde0123", o.f, o.t, o.msg);
        end
        checks++;
        if (o.fc !== 16'(fail_model)) begin
            failures++; $display("FAIL fail_count_inc got=%0d want=%0d", o.fc, fail_model);
        end
        xact(0, 1, '0, rnd60(), 2, rnd36(), 0, 0, 0, 0, o);
        last_gnt = 1;
        checks++;
        if (o.fc !== 16'(fail_model) || o.f !== 1'b0) begin
            failures++; $display("FAIL fail_count_clean got=%0d f=%b want=%0d f=0", o.fc, o.f, fail_model);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        logic seen;
        logic [35:0] m;
        xact(0, 1, '0, rnd60(), -1, rnd36(), 0, 0, 0, 0, o);
        last_gnt = 1; fail_model++;
        checks++;
        if (o.rl != TO + 1) begin failures++; $display("FAIL tmo_lat got=%0d want=%0d", o.rl, TO + 1); end
        checks++;
        if (o.t !== 1'b1 || o.f !== 1'b0 || o.msg !== 36'h0 || o.chan !== 1'b1) begin
            failures++;
            $display("FAIL tmo_resp t=%b f=%b msg=%h chan=%b want t=1 f=0 msg=0 chan=1", o.t, o.f, o.msg, o.chan);
        end
        checks++;
        if (o.fc !== 16'(fail_model)) begin failures++; $display("FAIL tmo_count got=%0d want=%0d", o.fc, fail_model); end
        repeat (3) cyc();
        decDone = 1; decMessage = rnd36();
        cyc();
        decDone = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (respValid || decStart) seen = 1;
            cyc();
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL tmo_late_done got=1 want=0"); end
        m = rnd36();
        xact(1, 0, rnd60(), '0, TO, m, 0, 0, 0, 0, o);
        last_gnt = 0;
        checks++;
        if (o.t !== 1'b0 || o.msg !== m || o.rl != TO + 1) begin
            failures++; $display("FAIL tmo_tie t=%b msg=%h rl=%0d want t=0 msg=%h rl=%0d", o.t, o.msg, o.rl, m, TO + 1);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [59:0] w0, w1;
        w0 = rnd60(); w1 = rnd60();
        xact(1, 0, w0, w1, 2, rnd36(), 0, 10, 0, 1, o);
        last_gnt = 0;
        checks++;
        if (o.stable !== 1'b1 || o.leak !== 1'b0 || o.chan !== 1'b0) begin
            failures++; $display("FAIL bp_hold stable=%b leak=%b chan=%b want 1 0 0", o.stable, o.leak, o.chan);
        end
        #1;
        checks++;
        if ({ch1ReqReady, ch0ReqReady} !== 2'b10) begin
            failures++; $display("FAIL bp_next_grant got=%b%b want=10", ch1ReqReady, ch0ReqReady);
        end
        xact(0, 1, '0, w1, 3, rnd36(), 0, 0, 0, 0, o);
        last_gnt = 1;
        checks++;
        if (o.chan !== 1'b1 || o.dword !== w1 || o.st != 0) begin
            failures++; $display("FAIL bp_ch1 chan=%b word=%h st=%0d want chan=1 word=%h st=0", o.chan, o.dword, o.st, w1);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic v0, v1, f, done, ef, et;
        int ec, lat, erl;
        logic [35:0] m, em;
        logic [59:0] w0, w1;
        for (int k = 0; k < 10; k++) begin
            v0 = 1'($urandom_range(1, 0));
            v1 = v0 ? 1'($urandom_range(1, 0)) : 1'b1;
            f = 1'($urandom_range(1, 0));
            lat = $urandom_range(TO + 3, 1);
            m = rnd36(); w0 = rnd60(); w1 = rnd60();
            ec = exp_chan(v0, v1);
            done = (lat <= TO);
            em = done ? m : 36'h0;
            ef = done ? f : 1'b0;
            et = !done;
            erl = done ? lat + 1 : TO + 1;
            xact(v0, v1, w0, w1, lat, m, f, $urandom_range(4, 0), 0, 0, o);
            last_gnt = ec;
            if (ef || et) fail_model++;
            checks++;
            if (o.chan !== 1'(ec) || o.msg !== em || o.f !== ef || o.t !== et || o.rl != erl ||
                o.dword !== (ec ? w1 : w0) || o.stable !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d chan=%b msg=%h f=%b t=%b rl=%0d want chan=%0d msg=%h f=%b t=%b rl=%0d",
                         k, o.chan, o.msg, o.f, o.t, o.rl, ec, em, ef, et, erl);
            end
            checks++;
            if (o.fc !== 16'(fail_model)) begin
                failures++; $display("FAIL rand%0d_count got=%0d want=%0d", k, o.fc, fail_model);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        ch0ReqValid = 1; ch0Word = rnd60();
        cyc();
        ch0ReqValid = 0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({decStart, decWord, respValid, respChan, respMessage, respFail, respTimeout,
             failCount, ch0ReqReady, ch1ReqReady} !== '0) begin
            failures++; $display("FAIL mid_reset_async failCount=%0d decWord=%h want 0", failCount, decWord);
        end
        cyc();
        rst_n = 1'b1;
        last_gnt = 1; fail_model = 0;
        cyc();
        decDone = 1; decMessage = rnd36();
        cyc();
        decDone = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (respValid || decStart) seen = 1;
            cyc();
        end
        checks++;
        if (seen !== 1'b0 || failCount !== 16'd0) begin
            failures++; $display("FAIL mid_reset_no_resp seen=%b fc=%0d want 0 0", seen, failCount);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ch0ReqValid = 0; ch1ReqValid = 0; ch0Word = '0; ch1Word = '0;
        decDone = 0; decFail = 0; decMessage = '0; respReady = 0;
        last_gnt = 1; fail_model = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_fail_count();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
